// File: rtl/handshake_constant_buffered.sv
// Elastic constant source: each accepted ctrl token emits REPEAT copies of VALUE.
// Optional zero-latency path when empty: define HANDSHAKE_CONSTANT_BYPASS_EN.
module handshake_constant_buffered #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] VALUE      = DATA_WIDTH'(1),
    parameter int                    DEPTH      = 2,
    parameter int                    REPEAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int CAP = DEPTH * REPEAT;
    localparam int CW  = $clog2(CAP + 1);

    localparam logic [CW-1:0] CAP_C = CW'(CAP);
    localparam logic [CW-1:0] REP_C = CW'(REPEAT);
    localparam logic [CW-1:0] LIM_C = CW'(CAP - REPEAT);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          ready_q;
    logic          valid_q;
    logic          ctrl_fire;
    logic          outs_fire;

    assign outs       = VALUE;
    assign ctrl_ready = ready_q;

`ifdef HANDSHAKE_CONSTANT_BYPASS_EN
    // valid_q is low exactly when cnt is zero, so the OR only acts when empty
    assign outs_valid = valid_q | (ctrl_valid & ready_q);
`else
    assign outs_valid = valid_q;
`endif

    assign ctrl_fire = ctrl_valid & ctrl_ready;
    assign outs_fire = outs_valid & outs_ready;

    always_comb begin
        cnt_next = cnt;
        if (ctrl_fire)
            cnt_next = cnt_next + REP_C;
        if (outs_fire)
            cnt_next = cnt_next - ONE_C;
    end

    // Flags are derived from cnt_next so both outputs come straight from flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            ready_q <= (cnt_next <= LIM_C);
            valid_q <= (cnt_next != '0);
        end
    end

    cnt_le_cap: assert property (
        @(posedge clk) disable iff (!rst) cnt <= CAP_C
    );

endmodule

// File: tb/tb_handshake_constant_buffered.sv
// Directed bench for handshake_constant_buffered, two parameter sets.
// Expectations follow HANDSHAKE_CONSTANT_BYPASS_EN when defined.
module tb_handshake_constant_buffered;

`ifdef HANDSHAKE_CONSTANT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;

    logic        a_cv;
    logic        a_cr;
    logic [31:0] a_outs;
    logic        a_ov;
    logic        a_or;

    logic        b_cv;
    logic        b_cr;
    logic [7:0]  b_outs;
    logic        b_ov;
    logic        b_or;

    int n_chk;
    int n_pass;

    handshake_constant_buffered #(
        .DATA_WIDTH(32),
        .VALUE     (32'd1),
        .DEPTH     (2),
        .REPEAT    (1)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .ctrl_valid(a_cv),
        .ctrl_ready(a_cr),
        .outs      (a_outs),
        .outs_valid(a_ov),
        .outs_ready(a_or)
    );

    handshake_constant_buffered #(
        .DATA_WIDTH(8),
        .VALUE     (8'h5A),
        .DEPTH     (2),
        .REPEAT    (3)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .ctrl_valid(b_cv),
        .ctrl_ready(b_cr),
        .outs      (b_outs),
        .outs_valid(b_ov),
        .outs_ready(b_or)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // inputs change 1 after the rising edge, outputs sampled at the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        int acc;
        int fires;
        int rdy_lo;
        int first;
        int last;
        bit drained;

        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b0;
        a_cv   = 1'b0;
        a_or   = 1'b0;
        b_cv   = 1'b0;
        b_or   = 1'b0;

        // reset state
        repeat (3) tick();
        settle();
        check("rst_valid", 32'(a_ov), 32'd0);
        check("rst_ready", 32'(a_cr), 32'd1);
        check("rst_outs", a_outs, 32'd1);
        check("rst_outs_b", 32'(b_outs), 32'h5A);
        tick();
        rst = 1'b1;
        settle();
        check("rel_valid", 32'(a_ov), 32'd0);
        check("rel_ready", 32'(a_cr), 32'd1);

        // single ctrl pulse, consumer ready
        tick();
        a_cv = 1'b1;
        a_or = 1'b1;
        settle();
        check("pulse_c0", 32'(a_ov), 32'(BYP));
        tick();
        a_cv = 1'b0;
        settle();
        check("pulse_c1", 32'(a_ov), 32'(!BYP));
        tick();
        settle();
        check("pulse_c2", 32'(a_ov), 32'd0);

        // fill with a stalled consumer
        tick();
        a_or = 1'b0;
        a_cv = 1'b1;
        acc  = 0;
        settle();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                tick();
                settle();
            end
            if (a_cv && a_cr)
                acc++;
        end
        check("fill_accepts", 32'(acc), 32'd2);
        check("full_ready", 32'(a_cr), 32'd0);
        check("full_valid", 32'(a_ov), 32'd1);
        tick();
        a_or = 1'b1;
        settle();
        check("full_no_comb", 32'(a_cr), 32'd0);
        tick();
        settle();
        check("full_reopen", 32'(a_cr), 32'd1);
        tick();
        a_cv    = 1'b0;
        drained = 1'b0;
        settle();
        for (int i = 0; i < 6; i++) begin
            if (!a_ov) begin
                drained = 1'b1;
                break;
            end
            tick();
            settle();
        end
        check("fill_drain", 32'(drained), 32'd1);

        // REPEAT=3 burst of 8'h5A
        tick();
        b_or  = 1'b1;
        b_cv  = 1'b1;
        fires = 0;
        first = -1;
        last  = -1;
        settle();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                tick();
                b_cv = 1'b0;
                settle();
            end
            if (b_ov && b_or) begin
                fires++;
                if (first < 0)
                    first = i;
                last = i;
                check("rep_outs", 32'(b_outs), 32'h5A);
            end
        end
        check("rep_fires", 32'(fires), 32'd3);
        check("rep_contig", 32'(last - first + 1), 32'd3);
        check("rep_start", 32'(first), BYP ? 32'd0 : 32'd1);

        // streaming throughput
        tick();
        a_cv   = 1'b1;
        a_or   = 1'b1;
        fires  = 0;
        rdy_lo = 0;
        settle();
        for (int i = 0; i < 100; i++) begin
            if (i > 0) begin
                tick();
                settle();
            end
            if (a_ov && a_or)
                fires++;
            if (!a_cr)
                rdy_lo++;
        end
        check("stream_fires", 32'(fires), BYP ? 32'd100 : 32'd99);
        check("stream_ready", 32'(rdy_lo), 32'd0);
        tick();
        a_cv = 1'b0;
        tick();
        settle();
        check("stream_drain", 32'(a_ov), 32'd0);

        // reset while holding two tokens
        tick();
        a_or = 1'b0;
        a_cv = 1'b1;
        tick();
        tick();
        a_cv = 1'b0;
        settle();
        check("pre_rst_valid", 32'(a_ov), 32'd1);
        check("pre_rst_ready", 32'(a_cr), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("async_valid", 32'(a_ov), 32'd0);
        check("async_ready", 32'(a_cr), 32'd1);
        tick();
        tick();
        rst   = 1'b1;
        a_or  = 1'b1;
        fires = 0;
        settle();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
                settle();
            end
            if (a_ov && a_or)
                fires++;
        end
        check("no_stale", 32'(fires), 32'd0);
        check("post_rst_outs", a_outs, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
